// File: rtl/tessia_mem_pkg.sv
// Shared definitions for the data-memory controller: FSM states, wait-state limit, default widths.
package tessia_mem_pkg;

    localparam int DEF_DATA_W      = 32;
    localparam int DEF_ADDR_W      = 32;
    localparam int DEF_DEPTH       = 64;
    localparam int MAX_WAIT_STATES = 15;
    localparam int CNT_W           = $clog2(MAX_WAIT_STATES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    // Index width that stays legal for a single-word memory.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// DEPTH x DATA_W word storage: byte-enabled synchronous write, combinational read.
module data_mem_array
    import tessia_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int IDX_W  = idx_width(DEF_DEPTH)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [IDX_W-1:0]    idx,
    input  logic [DATA_W/8-1:0] be,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // No reset: contents survive a controller reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/data_mem_ctrl.sv
// Wait-stated data-memory controller: one access in flight, response WAIT_STATES+1 cycles after accept.
module data_mem_ctrl
    import tessia_mem_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int WAIT_STATES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                stall
);

    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int IDX_W = idx_width(DEPTH);

    mem_state_t        state, next_state;
    logic [CNT_W-1:0]  cnt;
    logic              accept, req_err;
    logic              we_q, err_q, mem_we;
    logic [IDX_W-1:0]  idx_q;
    logic [BE_W-1:0]   be_q;
    logic [DATA_W-1:0] wdata_q, rd_word, rdata_hold;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid & req_ready;
    assign req_err   = ((req_addr & ADDR_W'(BE_W - 1)) != '0) ||
                       ((req_addr >> OFF_W) >= ADDR_W'(DEPTH));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = (WAIT_STATES == 0) ? RESP : WAIT;
            WAIT:    if (cnt == CNT_W'(1)) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            idx_q      <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            rdata_hold <= '0;
        end else begin
            if (accept) begin
                cnt     <= CNT_W'(WAIT_STATES);
                we_q    <= req_we;
                err_q   <= req_err;
                idx_q   <= req_addr[OFF_W +: IDX_W];
                be_q    <= req_be;
                wdata_q <= req_wdata;
            end else if (state == WAIT) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (state == RESP) rdata_hold <= rsp_rdata;
        end
    end

    // Read data is taken in RESP before the write lands on the edge leaving RESP.
    assign rsp_valid = (state == RESP);
    assign rsp_err   = rsp_valid & err_q;
    assign rsp_rdata = rsp_valid ? ((err_q | we_q) ? '0 : rd_word) : rdata_hold;
    assign stall     = (state == WAIT) | (req_ready & req_valid);
    assign mem_we    = rsp_valid & we_q & ~err_q;

    data_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .idx   (idx_q),
        .be    (be_q),
        .wdata (wdata_q),
        .rdata (rd_word)
    );

endmodule
